// File: rtl/slot_deserializer.sv
// slot_deserializer: rebuilds WIDTH-bit words from a slot-tagged serial bit stream
// and hands them downstream over valid/ready, flagging sequencing errors and overruns.
`default_nettype none

module slot_deserializer #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             uclk,
  input  logic             urst_n,
  input  logic             in_en,
  input  logic             in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             seq_err,
  output logic             overrun,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [0:0] {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] c_FIRST = '0;
  localparam logic [SEL_W-1:0] c_ONE   = SEL_W'(1);
  localparam logic [SEL_W-1:0] c_LAST  = SEL_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_expect;
  logic [SEL_W-1:0] w_expect_nxt;
  logic [WIDTH-2:0] r_buf;
  logic             w_wr_en;
  logic             w_complete;
  logic             w_seq_err;
  logic [WIDTH-1:0] w_word;

  logic [WIDTH-1:0] r_out_word;
  logic             r_out_valid;
  logic             r_seq_err;
  logic             r_overrun;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_frame_cnt;

  always_ff @(posedge uclk) begin
    if (!urst_n) begin
      r_state  <= HUNT;
      r_expect <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_expect <= w_expect_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_expect_nxt = r_expect;
    w_wr_en      = 1'b0;
    w_complete   = 1'b0;
    w_seq_err    = 1'b0;
    case (r_state)
      HUNT: begin
        if (in_en && in_sel == c_FIRST) begin
          w_wr_en      = 1'b1;
          w_expect_nxt = c_ONE;
          w_state_nxt  = ASSEMBLE;
        end
      end
      ASSEMBLE: begin
        if (in_en) begin
          if (in_sel == r_expect) begin
            w_wr_en      = 1'b1;
            w_expect_nxt = r_expect + c_ONE;
            if (in_sel == c_LAST) begin
              w_complete  = 1'b1;
              w_state_nxt = HUNT;
            end
          end else begin
            w_seq_err = 1'b1;
            // A misplaced slot 0 is treated as the start of a fresh frame.
            if (in_sel == c_FIRST) begin
              w_wr_en      = 1'b1;
              w_expect_nxt = c_ONE;
            end else begin
              w_state_nxt = HUNT;
            end
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // The top slot bypasses the buffer and goes straight into the finished word.
  assign w_word = {in_data, r_buf};

  always_ff @(posedge uclk) begin
    if (!urst_n) begin
      r_buf <= '0;
    end else begin
      for (int k = 0; k < WIDTH - 1; k++) begin
        if (w_wr_en && in_sel == SEL_W'(k)) begin
          r_buf[k] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge uclk) begin
    if (!urst_n) begin
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_seq_err   <= 1'b0;
      r_overrun   <= 1'b0;
      r_err_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_seq_err <= w_seq_err;
      r_overrun <= 1'b0;
      if (w_seq_err && r_err_cnt != {CNT_W{1'b1}}) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_complete) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        if (!r_out_valid || out_ready) begin
          r_out_word  <= w_word;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_word  = r_out_word;
  assign out_valid = r_out_valid;
  assign seq_err   = r_seq_err;
  assign overrun   = r_overrun;
  assign err_cnt   = r_err_cnt;
  assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_slot_deserializer.sv
// Scoreboard bench for slot_deserializer: directed frames, expected words queued at issue.
`default_nettype none

module tb_slot_deserializer;

  localparam int WIDTH = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  logic             uclk;
  logic             urst_n;
  logic             in_en;
  logic             in_data;
  logic [SEL_W-1:0] in_sel;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             seq_err;
  logic             overrun;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] frame_cnt;

  slot_deserializer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .uclk(uclk), .urst_n(urst_n), .in_en(in_en), .in_data(in_data),
    .in_sel(in_sel), .out_ready(out_ready), .out_word(out_word),
    .out_valid(out_valid), .seq_err(seq_err), .overrun(overrun),
    .err_cnt(err_cnt), .frame_cnt(frame_cnt)
  );

  initial uclk = 1'b0;
  always #5 uclk = ~uclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int seq_seen = 0;
  int ovr_seen = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               acc_cyc[$];

  always @(posedge uclk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge uclk) begin
    if (seq_err) seq_seen++;
    if (overrun) ovr_seen++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", int'(out_word), -1);
      end else begin
        check("out_word", int'(out_word), int'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    in_en = 1'b0;
    repeat (n) @(posedge uclk);
    #1;
  endtask

  task automatic send_slot(input int sel, input logic d);
    in_en   = 1'b1;
    in_sel  = SEL_W'(sel);
    in_data = d;
    @(posedge uclk);
    #1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w);
    for (int k = 0; k < WIDTH; k++) send_slot(k, w[k]);
  endtask

  task automatic do_reset();
    check("queue_empty_before_reset", exp_q.size(), 0);
    urst_n = 1'b0;
    in_en  = 1'b0;
    repeat (2) @(posedge uclk);
    #1;
    urst_n = 1'b1;
  endtask

  int s0, o0, a0;

  initial begin
    urst_n = 1'b0; in_en = 1'b0; in_data = 1'b0; in_sel = '0; out_ready = 1'b1;
    repeat (2) @(posedge uclk);
    #1;
    urst_n = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_word", int'(out_word), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_err_cnt", int'(err_cnt), 0);

    // 1: single frame, data 1,1,0,1 in slots 0..3
    s0 = seq_seen;
    exp_q.push_back(4'hB);
    send_frame(4'hB);
    check("t1_valid_after_last", int'(out_valid), 1);
    check("t1_frame_cnt", int'(frame_cnt), 1);
    idle(1);
    check("t1_valid_one_cycle", int'(out_valid), 0);
    check("t1_seq_err", seq_seen - s0, 0);

    // 2: back-to-back frames
    do_reset();
    a0 = acc_cyc.size();
    exp_q.push_back(4'hB); exp_q.push_back(4'h6); exp_q.push_back(4'hF);
    send_frame(4'hB); send_frame(4'h6); send_frame(4'hF);
    idle(2);
    check("t2_words", acc_cyc.size() - a0, 3);
    if (acc_cyc.size() - a0 == 3) begin
      check("t2_gap1", acc_cyc[a0+1] - acc_cyc[a0], 4);
      check("t2_gap2", acc_cyc[a0+2] - acc_cyc[a0+1], 4);
    end
    check("t2_frame_cnt", int'(frame_cnt), 3);

    // 3: stream starting mid-frame
    do_reset();
    s0 = seq_seen;
    send_slot(2, 1'b1); send_slot(3, 1'b1);
    exp_q.push_back(4'h9);
    send_frame(4'h9);
    idle(2);
    check("t3_seq_err", seq_seen - s0, 0);
    check("t3_err_cnt", int'(err_cnt), 0);
    check("t3_frame_cnt", int'(frame_cnt), 1);

    // 4: slot sequence 0,1,3 then a clean frame
    do_reset();
    s0 = seq_seen;
    send_slot(0, 1'b1); send_slot(1, 1'b1); send_slot(3, 1'b1);
    check("t4_seq_err_pulse", int'(seq_err), 1);
    check("t4_no_word", int'(out_valid), 0);
    exp_q.push_back(4'hA);
    send_frame(4'hA);
    idle(2);
    check("t4_err_cnt", int'(err_cnt), 1);
    check("t4_seq_count", seq_seen - s0, 1);
    check("t4_frame_cnt", int'(frame_cnt), 1);

    // 5: backpressure causes overrun
    do_reset();
    o0 = ovr_seen;
    out_ready = 1'b0;
    exp_q.push_back(4'h3);
    send_frame(4'h3);
    send_frame(4'hC);
    check("t5_overrun_pulse", int'(overrun), 1);
    check("t5_valid_held", int'(out_valid), 1);
    check("t5_word_held", int'(out_word), 3);
    check("t5_frame_cnt", int'(frame_cnt), 2);
    idle(1);
    check("t5_overrun_one_cycle", int'(overrun), 0);
    check("t5_overrun_count", ovr_seen - o0, 1);
    out_ready = 1'b1;
    idle(1);
    check("t5_valid_cleared", int'(out_valid), 0);

    // 6: stall inside a frame, then reset during a partial frame
    do_reset();
    exp_q.push_back(4'h5);
    send_slot(0, 1'b1); send_slot(1, 1'b0);
    idle(3);
    send_slot(2, 1'b1); send_slot(3, 1'b0);
    idle(1);
    check("t6_frame_cnt_stall", int'(frame_cnt), 1);
    send_slot(0, 1'b0); send_slot(1, 1'b1);
    urst_n = 1'b0;
    in_en  = 1'b0;
    @(posedge uclk);
    #1;
    urst_n = 1'b1;
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_word", int'(out_word), 0);
    check("t6_rst_frame_cnt", int'(frame_cnt), 0);
    check("t6_rst_err_cnt", int'(err_cnt), 0);
    check("t6_rst_seq_err", int'(seq_err), 0);
    check("t6_rst_overrun", int'(overrun), 0);
    // A surviving partial frame would complete on these slots.
    send_slot(2, 1'b1); send_slot(3, 1'b1);
    idle(1);
    check("t6_partial_discarded", int'(frame_cnt), 0);
    exp_q.push_back(4'h7);
    send_frame(4'h7);
    idle(2);
    check("t6_frame_cnt", int'(frame_cnt), 1);
    check("end_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
